ram_latency_responder: RTL and testbench
========================================

Name: ram_latency_responder

Overview:
- RAM-side responder for the memory controller's RAM port: consumes ramREN/ramWEN/ramaddr/ramstore and answers with ramstate/ramload.
- Word-addressed storage with a programmable access latency; it is the far end of the arbitration interface.
- Used as the RAM in system simulation and as the behavioural target when verifying the memory controller.

Parameters:
- LAT, 2, wait cycles between request acceptance and ACCESS (0..15).
- DEPTH, 1024, number of 32-bit words stored; any value from 1 to 65536.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  synchronous active-high reset
- ramREN  input  1  read request, level, held by initiator until ACCESS
- ramWEN  input  1  write request, level, held by initiator until ACCESS
- ramaddr  input  32  byte address (word_t); word index = ramaddr[31:2]
- ramstore  input  32  write data, sampled on the ACCESS cycle
- ramload  output  32  read data, valid only while ramstate==ACCESS and ramREN, else 0
- ramstate  output  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- acc_count  output  32  count of completed accesses (reads+writes) since reset, wraps at 2^32

Behaviour:
- Internal registers:
  - trk_valid (1) and trk_op (1, 1=write): the tracked request.
  - trk_addr (32).
  - cnt (4).
  - mem[DEPTH] x 32.
  - acc_count.
- "Live request" = ramREN^ramWEN. "Match" = live request && trk_valid && trk_addr==ramaddr && trk_op==ramWEN.
- Request is illegal if any of the following holds:
  - ramREN&&ramWEN.
  - ramaddr[1:0]!=0.
  - ramaddr[31:2] >= DEPTH.
- ramstate is combinational from registers plus live inputs, in priority order:
  - RST=1 -> FREE.
  - Illegal request -> ERROR.
  - No request -> FREE.
  - Match && cnt==0 -> ACCESS.
  - Otherwise -> BUSY.
- Sequential update on each rising edge:
  - RST: trk_valid=0, cnt=0, acc_count=0. mem contents are not cleared; they are zero at time 0.
  - ERROR or FREE cycle: trk_valid=0.
  - BUSY with no match (new or changed request): trk_valid=1; trk_addr=ramaddr; trk_op=ramWEN; cnt=LAT.
  - BUSY with match: cnt=cnt-1.
  - ACCESS: trk_valid=0; acc_count+1. If ramWEN, mem[ramaddr[31:2]]=ramstore.
- Latency:
  - Request first presented in cycle t (trk_valid=0) shows BUSY in cycles t..t+LAT.
  - ACCESS occurs in cycle t+LAT+1, for exactly one cycle.
  - With LAT=0, ACCESS occurs at t+1.
- Held request after ACCESS: trk_valid was cleared, so the next cycle is BUSY and a fresh full-latency transaction begins. There is no back-to-back ACCESS.
- Address or op change mid-BUSY: the transaction restarts. The new request is tracked, cnt=LAT, and the earlier request is dropped with no write.
- Request withdrawn mid-BUSY: FREE that cycle, tracking cleared, no side effect.
- ramload = mem[ramaddr[31:2]] only in ACCESS with ramREN; 0 in every other case, including during RST.
- Read-after-write: a write committed at edge e is visible to any ACCESS read after e.
- Reset mid-transaction: the pending access is aborted, with no write and no count. The first cycle after RST deasserts treats a held request as new (BUSY, full latency).
- Reset output values: ramstate=FREE, ramload=0, acc_count=0.

Test Plan:
- LAT=2, write ramaddr=0x10, ramstore=0xDEADBEEF held from cycle t:
  - BUSY at t, t+1, t+2; ACCESS at t+3; mem[4]=0xDEADBEEF; acc_count=1.
  - Then read 0x10: ACCESS 3 cycles later with ramload=0xDEADBEEF; acc_count=2.
- LAT=2, read 0x20 for 2 cycles, then switch to read 0x24:
  - BUSY persists.
  - ACCESS occurs exactly 3 cycles after the switch, with ramload=mem[9].
- Illegal requests, each held for one cycle:
  - ramREN=ramWEN=1 -> ERROR.
  - ramaddr=0x13 -> ERROR.
  - ramaddr=DEPTH*4 -> ERROR.
  - In all three cases no memory change and acc_count unchanged.
- LAT=2, write 0x40 with value 0x1234 held continuously for 8 cycles:
  - ACCESS at t+3 and t+7, BUSY otherwise.
  - acc_count=2; mem[16]=0x1234.
- Reset mid-operation: assert RST at t+1 of a write to 0x0 with value 0xAAAA, hold 1 cycle, keep request asserted:
  - FREE during RST.
  - Write not committed before RST; ACCESS 3 cycles after RST deasserts.
  - acc_count=1 afterwards.
- LAT=0, read 0x8 -> BUSY at t, ACCESS at t+1, BUSY at t+2 if the request is still held.

Source files
------------

// File: rtl/ram_latency_responder_if.sv
// RAM-port bundle between the memory controller and the RAM-side responder.
// The controller (master) drives the request. The responder (slave) answers with state and load data.
interface ram_latency_responder_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

// File: rtl/ram_latency_responder.sv
// Word-addressed RAM responder with a programmable access latency.
// A request that is held steady is answered with BUSY for LAT+1 cycles, then ACCESS for exactly one cycle.
// Any change of address or operation restarts the wait.
module ram_latency_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  ram_latency_responder_if.slave ram,
  output logic [31:0]            acc_count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_CNT = 4'(LAT);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        trk_valid_q, trk_valid_d;
  logic        trk_op_q, trk_op_d;
  logic [31:0] trk_addr_q, trk_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] acc_count_q, acc_count_d;

  // Storage starts out all-zero and is never cleared by reset.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic          any_req;
  logic          live_req;
  logic          illegal_req;
  logic          match;
  logic [1:0]    state;
  logic [AW-1:0] word_idx;
  logic          mem_we;

  // Decode the live request. A misaligned or out-of-range address only counts as illegal when some request is present.
  always_comb begin
    any_req     = ram.ramREN | ram.ramWEN;
    live_req    = ram.ramREN ^ ram.ramWEN;
    illegal_req = any_req &&
                  ((ram.ramREN && ram.ramWEN) ||
                   (ram.ramaddr[1:0] != 2'b00) ||
                   ({2'b00, ram.ramaddr[31:2]} >= DEPTH_W));
    match       = live_req && trk_valid_q &&
                  (trk_addr_q == ram.ramaddr) && (trk_op_q == ram.ramWEN);
    word_idx    = ram.ramaddr[AW+1:2];
  end

  // Port state is resolved in priority order: reset, illegal, idle, ready, waiting.
  always_comb begin
    state = BUSY;
    if (RST)
      state = FREE;
    else if (illegal_req)
      state = ERROR;
    else if (!live_req)
      state = FREE;
    else if (match && (cnt_q == 4'd0))
      state = ACCESS;
  end

  // Track the request being served and count down its latency. A new or changed request restarts the count.
  always_comb begin
    trk_valid_d = trk_valid_q;
    trk_op_d    = trk_op_q;
    trk_addr_d  = trk_addr_q;
    cnt_d       = cnt_q;
    acc_count_d = acc_count_q;
    mem_we      = 1'b0;
    if (RST) begin
      trk_valid_d = 1'b0;
      cnt_d       = 4'd0;
      acc_count_d = 32'd0;
    end else begin
      case (state)
        BUSY: begin
          if (match) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            trk_valid_d = 1'b1;
            trk_addr_d  = ram.ramaddr;
            trk_op_d    = ram.ramWEN;
            cnt_d       = LAT_CNT;
          end
        end
        ACCESS: begin
          trk_valid_d = 1'b0;
          acc_count_d = acc_count_q + 32'd1;
          mem_we      = ram.ramWEN;
        end
        default: begin
          trk_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Register the tracker and the access counter.
  always_ff @(posedge CLK) begin
    trk_valid_q <= trk_valid_d;
    trk_op_q    <= trk_op_d;
    trk_addr_q  <= trk_addr_d;
    cnt_q       <= cnt_d;
    acc_count_q <= acc_count_d;
  end

  // Commit write data on the single ACCESS cycle of a write.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem_q[word_idx] <= ram.ramstore;
  end

  // Drive load data only while a read is being answered.
  always_comb begin
    ram.ramstate = state;
    ram.ramload  = 32'd0;
    if ((state == ACCESS) && ram.ramREN)
      ram.ramload = mem_q[word_idx];
  end

  assign acc_count = acc_count_q;

endmodule

// File: tb/tb_ram_latency_responder.sv
// Bench for ram_latency_responder with two instances: LAT=2/DEPTH=64 and LAT=0/DEPTH=1024.
// A transaction-level model predicts each cycle's state, load and access count.
module tb_ram_latency_responder;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst;

  logic        in_ren   [2];
  logic        in_wen   [2];
  logic [31:0] in_addr  [2];
  logic [31:0] in_store [2];

  logic [1:0]  obs_state [2];
  logic [31:0] obs_load  [2];
  logic [31:0] obs_acc   [2];

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: the request seen last cycle, how many cycles it has been held, stored words and access count.
  bit          m_valid [2];
  bit          m_op    [2];
  logic [31:0] m_addr  [2];
  int          m_age   [2];
  logic [31:0] m_acc   [2];
  bit   [31:0] m_mem   [2][1024];

  ram_latency_responder_if bus0 ();
  ram_latency_responder_if bus1 ();

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  assign bus0.ramREN   = in_ren[0];
  assign bus0.ramWEN   = in_wen[0];
  assign bus0.ramaddr  = in_addr[0];
  assign bus0.ramstore = in_store[0];
  assign bus1.ramREN   = in_ren[1];
  assign bus1.ramWEN   = in_wen[1];
  assign bus1.ramaddr  = in_addr[1];
  assign bus1.ramstore = in_store[1];

  assign obs_state[0] = bus0.ramstate;
  assign obs_load[0]  = bus0.ramload;
  assign obs_state[1] = bus1.ramstate;
  assign obs_load[1]  = bus1.ramload;

  ram_latency_responder #(.LAT(2), .DEPTH(64)) dut0 (
    .CLK       (clk),
    .RST       (rst),
    .ram       (bus0.slave),
    .acc_count (obs_acc[0])
  );

  ram_latency_responder #(.LAT(0), .DEPTH(1024)) dut1 (
    .CLK       (clk),
    .RST       (rst),
    .ram       (bus1.slave),
    .acc_count (obs_acc[1])
  );

  // Predict one cycle for instance k from its inputs, then advance the model past the coming edge.
  task automatic modelCycle(input int k, output logic [1:0] es, output logic [31:0] el,
                            output logic [31:0] ea);
    int lat;
    int depth;
    bit any;
    bit bad;
    lat   = (k == 0) ? 2 : 0;
    depth = (k == 0) ? 64 : 1024;
    ea    = m_acc[k];
    el    = 32'd0;
    any   = in_ren[k] | in_wen[k];
    bad   = any && ((in_ren[k] && in_wen[k]) || (in_addr[k][1:0] != 2'b00) ||
                    ((in_addr[k] >> 2) >= 32'(depth)));
    if (rst) begin
      es         = S_FREE;
      m_valid[k] = 1'b0;
      m_acc[k]   = 32'd0;
    end else if (bad) begin
      es         = S_ERROR;
      m_valid[k] = 1'b0;
    end else if (!any) begin
      es         = S_FREE;
      m_valid[k] = 1'b0;
    end else if (m_valid[k] && (m_addr[k] == in_addr[k]) && (m_op[k] == in_wen[k])) begin
      m_age[k] = m_age[k] + 1;
      if (m_age[k] == lat + 1) begin
        es         = S_ACCESS;
        m_valid[k] = 1'b0;
        m_acc[k]   = m_acc[k] + 32'd1;
        if (in_wen[k])
          m_mem[k][in_addr[k] >> 2] = in_store[k];
        else
          el = m_mem[k][in_addr[k] >> 2];
      end else begin
        es = S_BUSY;
      end
    end else begin
      m_valid[k] = 1'b1;
      m_addr[k]  = in_addr[k];
      m_op[k]    = in_wen[k];
      m_age[k]   = 0;
      es         = S_BUSY;
    end
  endtask

  // Compare both instances' outputs against the model for the current cycle.
  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      logic [1:0]  es;
      logic [31:0] el;
      logic [31:0] ea;
      modelCycle(k, es, el, ea);
      n_cmp++;
      assert (obs_state[k] === es) else begin
        n_mis++;
        $error("[TB] FAIL ramstate%0d t=%0t observed=%0d expected=%0d", k, $time, obs_state[k], es);
      end
      n_cmp++;
      assert (obs_load[k] === el) else begin
        n_mis++;
        $error("[TB] FAIL ramload%0d t=%0t observed=%h expected=%h", k, $time, obs_load[k], el);
      end
      n_cmp++;
      assert (obs_acc[k] === ea) else begin
        n_mis++;
        $error("[TB] FAIL acc_count%0d t=%0t observed=%0d expected=%0d", k, $time, obs_acc[k], ea);
      end
    end
  endtask

  // Drive one cycle on instance d with the other instance idle, check it, and move to the next falling edge.
  task automatic applyStimulus(input int d, input logic r, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] store);
    for (int k = 0; k < 2; k++) begin
      in_ren[k]   = 1'b0;
      in_wen[k]   = 1'b0;
      in_addr[k]  = 32'd0;
      in_store[k] = 32'd0;
    end
    rst         = r;
    in_ren[d]   = ren;
    in_wen[d]   = wen;
    in_addr[d]  = addr;
    in_store[d] = store;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Directed scenarios followed by randomized held requests.
  initial begin
    for (int k = 0; k < 2; k++) begin
      in_ren[k]   = 1'b0;
      in_wen[k]   = 1'b0;
      in_addr[k]  = 32'd0;
      in_store[k] = 32'd0;
      m_valid[k]  = 1'b0;
      m_op[k]     = 1'b0;
      m_addr[k]   = 32'd0;
      m_age[k]    = 0;
      m_acc[k]    = 32'd0;
    end
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h0);

    // Write then read back at LAT=2.
    repeat (4) applyStimulus(0, 0, 0, 1, 32'h10, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h10, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);

    // Seed word 9, then read 0x20 briefly before switching to 0x24.
    repeat (4) applyStimulus(0, 0, 0, 1, 32'h24, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) applyStimulus(0, 0, 1, 0, 32'h20, 32'h0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h24, 32'h0);

    // Illegal requests leave memory and the count alone.
    applyStimulus(0, 0, 1, 1, 32'h10, 32'h11111111);
    applyStimulus(0, 0, 1, 0, 32'h13, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h13, 32'h22222222);
    applyStimulus(0, 0, 0, 1, 32'h100, 32'h33333333);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h10, 32'h0);

    // A held write produces repeated full-latency transactions.
    repeat (8) applyStimulus(0, 0, 0, 1, 32'h40, 32'h1234);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h40, 32'h0);

    // Reset in the middle of a write, with the request kept asserted.
    applyStimulus(0, 0, 0, 1, 32'h0, 32'hAAAA);
    applyStimulus(0, 1, 0, 1, 32'h0, 32'hAAAA);
    repeat (4) applyStimulus(0, 0, 0, 1, 32'h0, 32'hAAAA);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h0, 32'h0);

    // Zero-latency instance: ACCESS one cycle after the request appears.
    repeat (2) applyStimulus(1, 0, 0, 1, 32'h8, 32'h5555);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) applyStimulus(1, 0, 1, 0, 32'h8, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);

    // Randomized requests held for random lengths, with occasional illegal addresses and resets.
    for (int n = 0; n < 80; n++) begin
      int          d;
      int          len;
      int          kind;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
      d    = int'($urandom_range(0, 1));
      len  = int'($urandom_range(1, 6));
      kind = int'($urandom_range(0, 9));
      ren  = (kind < 5) || (kind == 9);
      wen  = (kind >= 5);
      addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 9) == 0)
        addr = addr | 32'h1;
      if ($urandom_range(0, 14) == 0)
        addr = addr + ((d == 0) ? 32'h100 : 32'h1000);
      data = $urandom();
      for (int c = 0; c < len; c++)
        applyStimulus(d, ($urandom_range(0, 39) == 0), ren, wen, addr, data);
      if ($urandom_range(0, 2) == 0)
        applyStimulus(d, 0, 0, 0, 32'h0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
    $finish;
  end

endmodule
